// File: rtl/mc14500b_seq_pkg.sv
// Shared definitions for the MC14500B program sequencer.
// Provides the ICU opcode encodings, the sequencer state type and a
// small helper that identifies store instructions. The ICU drives the
// data bus during a store.
package mc14500b_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_e;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    // Returns 1 when the ICU, not the sequencer, owns the data bus.
    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_STO) || (op == OP_STOC);
    endfunction

endpackage

// File: rtl/mc14500b_rstack.sv
// Circular return-address stack for the MC14500B sequencer.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push          write i_din as the new top (overwrites oldest when full)
//   i_pop           discard the top entry (ignored when empty)
//   i_din           return address to push
//   o_top_c         current top entry (combinational)
//   o_empty_c       no valid entries (combinational)
// Push has priority when push and pop are requested together.
module mc14500b_rstack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top_c,
    output logic         o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             full;

    // Top of stack sits one slot behind the write pointer, with wrap.
    always_comb begin
        top_ptr = (wr_ptr == '0) ? PTR_LAST : (wr_ptr - 1'b1);
    end

    assign o_top_c   = mem[top_ptr];
    assign o_empty_c = (count == '0);
    assign full      = (count == CNT_FULL);

    // Pointer/count update; a push on a full stack reuses the oldest slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (i_push) begin
            mem[wr_ptr] <= i_din;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : (wr_ptr + 1'b1);
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (i_pop && !o_empty_c) begin
            wr_ptr <= top_ptr;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mc14500b_seq.sv
// MC14500B program sequencer / system controller.
// Holds the PC, fetches {op,addr} words from an asynchronous ROM, hands
// the opcode to the ICU, serves the shared 1-bit data bus (input mux and
// output latch) and reacts to the ICU JMP/RTN/FLGF/FLGO strobes.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              leave IDLE/HALT and (re)start execution
//   o_pc, i_instr        ROM address and same-cycle ROM data {op,addr}
//   o_op                 opcode to the ICU (NOPO outside RUN)
//   o_icu_rst            synchronous reset to the ICU, high only in IDLE
//   io_d                 ICU data bus
//   i_wr..i_flgo         ICU strobes
//   i_in, o_out          external inputs (async) and output latch
//   o_tick               one-cycle pulse per executed NOPO
//   o_halted             high while halted
module mc14500b_seq
    import mc14500b_seq_pkg::*;
#(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned AW          = 4,
    parameter int unsigned NIN         = 8,
    parameter int unsigned NOUT        = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic [PC_W-1:0]   o_pc,
    input  logic [AW+3:0]     i_instr,
    output logic [3:0]        o_op,
    output logic              o_icu_rst,
    inout  wire               io_d,
    input  logic              i_wr,
    input  logic              i_jmp,
    input  logic              i_rtn,
    input  logic              i_flgf,
    input  logic              i_flgo,
    input  logic [NIN-1:0]    i_in,
    output logic [NOUT-1:0]   o_out,
    output logic              o_tick,
    output logic              o_halted
);

    seq_state_e      state;
    seq_state_e      state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [3:0]      op;
    logic [AW-1:0]   addr;
    logic            run;
    logic            stk_push;
    logic            stk_pop;
    logic            stk_empty;
    logic [PC_W-1:0] stk_top;
    logic [NIN-1:0]  in_meta;
    logic [NIN-1:0]  in_sync;
    logic            drive_en;
    logic            drive_val;

    assign op     = i_instr[AW+3:AW];
    assign addr   = i_instr[AW-1:0];
    assign run    = (state == SEQ_RUN);
    assign pc_inc = pc + 1'b1;
    assign o_pc   = pc;
    assign o_op   = run ? op : OP_NOPO;

    mc14500b_rstack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_rstack (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (stk_push),
        .i_pop     (stk_pop),
        .i_din     (pc_inc),
        .o_top_c   (stk_top),
        .o_empty_c (stk_empty)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next PC and stack control; JMP outranks RTN.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (i_start) begin
                    state_nxt = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (i_flgf) begin
                    state_nxt = SEQ_HALT;
                end
                if (i_jmp) begin
                    pc_nxt   = PC_W'(addr);
                    stk_push = 1'b1;
                end else if (i_rtn) begin
                    pc_nxt  = stk_empty ? '0 : stk_top;
                    stk_pop = !stk_empty;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            SEQ_HALT: begin
                if (i_start) begin
                    state_nxt = SEQ_RUN;
                end
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

    // PC and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc        <= '0;
            o_icu_rst <= 1'b1;
            o_halted  <= 1'b0;
            o_tick    <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            o_icu_rst <= (state_nxt == SEQ_IDLE);
            o_halted  <= (state_nxt == SEQ_HALT);
            o_tick    <= i_flgo & run;
        end
    end

    // Two-flop synchronizer for the asynchronous inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_meta <= '0;
            in_sync <= '0;
        end else begin
            in_meta <= i_in;
            in_sync <= in_meta;
        end
    end

    // Output latch; addresses beyond NOUT match no bit and are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out <= '0;
        end else if (run && i_wr) begin
            for (int i = 0; i < int'(NOUT); i++) begin
                if (addr == AW'(i)) begin
                    o_out[i] <= io_d;
                end
            end
        end
    end

    // Input mux onto the bus; released during stores and outside RUN.
    always_comb begin
        drive_en  = run && !op_is_store(op);
        drive_val = 1'b0;
        for (int i = 0; i < int'(NIN); i++) begin
            if (addr == AW'(i)) begin
                drive_val = in_sync[i];
            end
        end
    end

    assign io_d = drive_en ? drive_val : 1'bz;

endmodule

// File: tb/tb_mc14500b_seq.sv
// Directed bench for mc14500b_seq with a minimal ICU stand-in
// (RR/IEN/OEN, store drive, strobes decoded from o_op).
module tb_mc14500b_seq;
    import mc14500b_seq_pkg::*;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned NIN   = 8;
    localparam int unsigned NOUT  = 8;
    localparam int unsigned DEPTH = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] o_pc;
    logic [AW+3:0]   i_instr;
    logic [3:0]      o_op;
    logic            o_icu_rst;
    wire             io_d;
    logic            i_wr, i_jmp, i_rtn, i_flgf, i_flgo;
    logic [NIN-1:0]  i_in = '0;
    logic [NOUT-1:0] o_out;
    logic            o_tick;
    logic            o_halted;

    logic [AW+3:0]   rom [256];
    logic            icu_rr  = 1'b0;
    logic            icu_ien = 1'b0;
    logic            icu_oen = 1'b0;
    logic            probe_en  = 1'b0;
    logic            probe_val = 1'b0;
    logic            icu_sto;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc14500b_seq #(
        .PC_W(PC_W), .AW(AW), .NIN(NIN), .NOUT(NOUT), .STACK_DEPTH(DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .o_pc      (o_pc),
        .i_instr   (i_instr),
        .o_op      (o_op),
        .o_icu_rst (o_icu_rst),
        .io_d      (io_d),
        .i_wr      (i_wr),
        .i_jmp     (i_jmp),
        .i_rtn     (i_rtn),
        .i_flgf    (i_flgf),
        .i_flgo    (i_flgo),
        .i_in      (i_in),
        .o_out     (o_out),
        .o_tick    (o_tick),
        .o_halted  (o_halted)
    );

    assign i_instr = rom[o_pc];
    assign icu_sto = (o_op == OP_STO) || (o_op == OP_STOC);
    assign i_wr    = icu_sto & icu_oen;
    assign i_jmp   = (o_op == OP_JMP);
    assign i_rtn   = (o_op == OP_RTN);
    assign i_flgf  = (o_op == OP_NOPF);
    assign i_flgo  = (o_op == OP_NOPO);
    assign io_d    = icu_sto ? ((o_op == OP_STO) ? icu_rr : ~icu_rr)
                             : (probe_en ? probe_val : 1'bz);

    // ICU stand-in: only the registers these programs touch.
    always @(posedge clk) begin
        if (o_icu_rst) begin
            icu_rr  <= 1'b0;
            icu_ien <= 1'b0;
            icu_oen <= 1'b0;
        end else begin
            case (o_op)
                OP_LD:   icu_rr  <= io_d & icu_ien;
                OP_LDC:  icu_rr  <= ~io_d & icu_ien;
                OP_IEN:  icu_ien <= io_d;
                OP_OEN:  icu_oen <= io_d;
                default: ;
            endcase
        end
    end

    function automatic logic [AW+3:0] mk(input logic [3:0] op, input logic [7:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rom_clear;
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic reset_seq;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic go;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] nest_exp [11];

    initial begin
        // Reset state and free-running count with wrap
        rom_clear();
        reset_seq();
        chk("rst_pc", 32'(o_pc), 32'h0);
        chk("rst_icu_rst", 32'(o_icu_rst), 32'h1);
        chk("rst_halted", 32'(o_halted), 32'h0);
        chk("rst_tick", 32'(o_tick), 32'h0);
        chk("rst_out", 32'(o_out), 32'h0);
        chk("rst_op", 32'(o_op), 32'h0);
        go();
        chk("run_icu_rst", 32'(o_icu_rst), 32'h0);
        chk("run_pc0", 32'(o_pc), 32'h0);
        @(negedge clk);
        chk("run_pc1", 32'(o_pc), 32'h1);
        chk("run_tick", 32'(o_tick), 32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_pc2", 32'(o_pc), 32'h2);
        repeat (253) @(negedge clk);
        chk("pc_ff", 32'(o_pc), 32'hFF);
        @(negedge clk);
        chk("pc_wrap", 32'(o_pc), 32'h0);

        // I/O: IEN/OEN/LD/STO, dropped address, STOC, store of zero
        rom_clear();
        rom[0] = mk(OP_IEN, 8'd1);
        rom[1] = mk(OP_OEN, 8'd1);
        rom[2] = mk(OP_LD, 8'd3);
        rom[3] = mk(OP_STO, 8'd5);
        rom[4] = mk(OP_STO, 8'd12);
        rom[5] = mk(OP_LD, 8'd2);
        rom[6] = mk(OP_STOC, 8'd6);
        rom[7] = mk(OP_STO, 8'd1);
        rom[8] = mk(OP_LD, 8'd9);
        i_in = 8'h2B;
        reset_seq();
        probe_en = 1'b1; probe_val = 1'b0; #1;
        chk("idle_bus_free", 32'(io_d), 32'h0);
        probe_en = 1'b0;
        go();
        chk("io_ien_bus", 32'(io_d), 32'h1);
        repeat (2) @(negedge clk);
        chk("io_ld3_bus", 32'(io_d), 32'h1);
        @(negedge clk);
        chk("io_sto_bus", 32'(io_d), 32'h1);
        @(negedge clk);
        chk("io_out_sto5", 32'(o_out), 32'h20);
        @(negedge clk);
        chk("io_out_sto12", 32'(o_out), 32'h20);
        repeat (2) @(negedge clk);
        chk("io_out_stoc6", 32'(o_out), 32'h60);
        @(negedge clk);
        chk("io_out_sto1", 32'(o_out), 32'h60);
        chk("io_ld9_bus", 32'(io_d), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(o_out), 32'h0);
        chk("arst_pc", 32'(o_pc), 32'h0);
        chk("arst_icu_rst", 32'(o_icu_rst), 32'h1);
        @(negedge clk);

        // JMP/RTN and RTN on an empty stack
        rom_clear();
        rom[8'h10] = mk(OP_JMP, 8'h40);
        rom[8'h40] = mk(OP_RTN, 8'h00);
        rom[8'h12] = mk(OP_RTN, 8'h00);
        reset_seq();
        go();
        repeat (16) @(negedge clk);
        chk("jr_pc10", 32'(o_pc), 32'h10);
        @(negedge clk);
        chk("jr_pc40", 32'(o_pc), 32'h40);
        @(negedge clk);
        chk("jr_pc11", 32'(o_pc), 32'h11);
        @(negedge clk);
        chk("jr_pc12", 32'(o_pc), 32'h12);
        @(negedge clk);
        chk("jr_rtn_empty", 32'(o_pc), 32'h0);

        // Five nested calls on a four-deep stack
        rom_clear();
        rom[8'h00] = mk(OP_JMP, 8'h20);
        rom[8'h20] = mk(OP_JMP, 8'h30);
        rom[8'h30] = mk(OP_JMP, 8'h40);
        rom[8'h40] = mk(OP_JMP, 8'h50);
        rom[8'h50] = mk(OP_JMP, 8'h60);
        rom[8'h60] = mk(OP_RTN, 8'h00);
        rom[8'h51] = mk(OP_RTN, 8'h00);
        rom[8'h41] = mk(OP_RTN, 8'h00);
        rom[8'h31] = mk(OP_RTN, 8'h00);
        rom[8'h21] = mk(OP_RTN, 8'h00);
        nest_exp = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                     8'h51, 8'h41, 8'h31, 8'h21, 8'h00};
        reset_seq();
        go();
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("nest_pc%0d", k), 32'(o_pc), 32'(nest_exp[k]));
            @(negedge clk);
        end

        // Halt on NOPF, freeze, resume with ICU state kept
        rom_clear();
        rom[0] = mk(OP_IEN, 8'd1);
        rom[1] = mk(OP_LD, 8'd3);
        rom[7] = mk(OP_NOPF, 8'd0);
        rom[8] = mk(OP_OEN, 8'd1);
        rom[9] = mk(OP_STO, 8'd3);
        reset_seq();
        go();
        repeat (7) @(negedge clk);
        chk("h_pc7", 32'(o_pc), 32'h7);
        chk("h_not_halted", 32'(o_halted), 32'h0);
        chk("h_tick_nopo", 32'(o_tick), 32'h1);
        @(negedge clk);
        chk("h_halted", 32'(o_halted), 32'h1);
        chk("h_pc8", 32'(o_pc), 32'h8);
        chk("h_op", 32'(o_op), 32'h0);
        chk("h_tick_off", 32'(o_tick), 32'h0);
        repeat (3) @(negedge clk);
        chk("h_pc_frozen", 32'(o_pc), 32'h8);
        chk("h_icu_rst", 32'(o_icu_rst), 32'h0);
        probe_en = 1'b1; probe_val = 1'b0; #1;
        chk("h_bus_free", 32'(io_d), 32'h0);
        probe_en = 1'b0;
        go();
        chk("h_resume_pc", 32'(o_pc), 32'h8);
        chk("h_resume_flag", 32'(o_halted), 32'h0);
        repeat (2) @(negedge clk);
        chk("h_rr_kept", 32'(o_out), 32'h08);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
